// File: rtl/overlap_save_pkg.sv
// Shared types and helpers for the overlap-save framer.
// Counter widths derive from cnt_width() in the top, since a package cannot see module parameters.
package overlap_save_pkg;

  typedef enum logic [0:0] {
    StFill,
    StRun
  } state_e;

  // $clog2 with a floor of one bit, so a counter over a single value still has a width.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/os_shift_buffer.sv
// N_FFT x NB_DATA shift register. Index 0 is the oldest sample; new samples enter the top slice.
// Exposes the next-state contents so the framer can snapshot a frame that includes this cycle's sample.
module os_shift_buffer #(
  parameter int unsigned NB_DATA = 16,
  parameter int unsigned N_FFT   = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_shift,
  input  logic [NB_DATA-1:0]         i_data,
  output logic [NB_DATA*N_FFT-1:0]   o_taps_next
);

  logic [NB_DATA*N_FFT-1:0] taps_q;

  always_comb begin
    o_taps_next = taps_q;
    if (i_shift) begin
      o_taps_next = {i_data, taps_q[NB_DATA*N_FFT-1:NB_DATA]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      taps_q <= '0;
    end else begin
      taps_q <= o_taps_next;
    end
  end

endmodule

// File: rtl/overlap_save_framer.sv
// Overlap-save input framer: serial samples in, N_FFT-sample frames advancing by N_HOP out.
// Define OVERLAP_SAVE_ZERO_PREFILL_EN to start in RUN with a zeroed buffer (first frame after N_HOP).
module overlap_save_framer
  import overlap_save_pkg::*;
#(
  parameter int unsigned NB_DATA      = 16,
  parameter int unsigned N_FFT        = 32,
  parameter int unsigned N_HOP        = 16,
  parameter int unsigned NB_FRAME_CNT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [NB_DATA-1:0]         i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [NB_DATA*N_FFT-1:0]   o_data,
  output logic [NB_FRAME_CNT-1:0]    o_frame_cnt
);

  localparam int unsigned NB_FILL_CNT = cnt_width(N_FFT);
  localparam int unsigned NB_HOP_CNT  = cnt_width(N_HOP);
  localparam logic [NB_FILL_CNT-1:0] FillMax = NB_FILL_CNT'(N_FFT - 1);
  localparam logic [NB_HOP_CNT-1:0]  HopMax  = NB_HOP_CNT'(N_HOP - 1);

`ifdef OVERLAP_SAVE_ZERO_PREFILL_EN
  localparam state_e StReset = StRun;
`else
  localparam state_e StReset = StFill;
`endif

  state_e                      state_q, state_d;
  logic [NB_FILL_CNT-1:0]      fill_cnt_q, fill_cnt_d;
  logic [NB_HOP_CNT-1:0]       hop_cnt_q, hop_cnt_d;
  logic                        valid_q, valid_d;
  logic [NB_DATA*N_FFT-1:0]    frame_q, frame_d;
  logic [NB_FRAME_CNT-1:0]     frame_cnt_q, frame_cnt_d;
  logic [NB_DATA*N_FFT-1:0]    taps_next;
  logic                        acc;
  logic                        snap;
  logic                        frame_done_next;

  // Stall only when the sample we would take completes a frame that has nowhere to go.
  always_comb begin
    frame_done_next = (state_q == StFill) ? (fill_cnt_q == FillMax) : (hop_cnt_q == HopMax);
    o_ready         = !(frame_done_next && valid_q && !i_ready);
    acc             = i_valid && o_ready;
  end

  os_shift_buffer #(
    .NB_DATA (NB_DATA),
    .N_FFT   (N_FFT)
  ) u_shift_buffer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_shift     (acc),
    .i_data      (i_data),
    .o_taps_next (taps_next)
  );

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    hop_cnt_d  = hop_cnt_q;
    snap       = 1'b0;
    if (acc) begin
      unique case (state_q)
        StFill: begin
          if (fill_cnt_q == FillMax) begin
            snap       = 1'b1;
            state_d    = StRun;
            fill_cnt_d = '0;
            hop_cnt_d  = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + NB_FILL_CNT'(1);
          end
        end
        StRun: begin
          if (hop_cnt_q == HopMax) begin
            snap      = 1'b1;
            hop_cnt_d = '0;
          end else begin
            hop_cnt_d = hop_cnt_q + NB_HOP_CNT'(1);
          end
        end
        default: state_d = StReset;
      endcase
    end
  end

  // A snapshot wins over consumption, so back-to-back frames leave no bubble.
  always_comb begin
    valid_d     = valid_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;
    if (snap) begin
      valid_d     = 1'b1;
      frame_d     = taps_next;
      frame_cnt_d = frame_cnt_q + NB_FRAME_CNT'(1);
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StReset;
      fill_cnt_q  <= '0;
      hop_cnt_q   <= '0;
      valid_q     <= 1'b0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      hop_cnt_q   <= hop_cnt_d;
      valid_q     <= valid_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = frame_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_overlap_save_framer.sv
// Randomised bench for overlap_save_framer against a sample-history reference model.
module tb_overlap_save_framer;

  localparam int NB   = 16;
  localparam int NF   = 32;
  localparam int NH   = 16;
  localparam int NC   = 8;
  localparam int W    = NB * NF;
`ifdef OVERLAP_SAVE_ZERO_PREFILL_EN
  localparam int PRE  = NF - NH;
`else
  localparam int PRE  = 0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [NB-1:0] i_data = '0;
  logic          o_ready;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [W-1:0]  o_data;
  logic [NC-1:0] o_frame_cnt;

  overlap_save_framer #(
    .NB_DATA      (NB),
    .N_FFT        (NF),
    .N_HOP        (NH),
    .NB_FRAME_CNT (NC)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the accepted-sample history and the frame that should be on the output.
  logic [NB-1:0] hist[$];
  int            n_acc;
  logic          exp_valid;
  logic [W-1:0]  exp_frame;
  logic [NC-1:0] exp_cnt;
  bit            saw_wrap = 0;
  logic [NC-1:0] prev_cnt = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < PRE; k++) hist.push_back('0);
    n_acc     = 0;
    exp_valid = 1'b0;
    exp_frame = '0;
    exp_cnt   = '0;
  endtask

  task automatic check_outputs();
    check("o_valid", W'(o_valid), W'(exp_valid));
    check("o_frame_cnt", W'(o_frame_cnt), W'(exp_cnt));
    check("o_data", o_data, exp_frame);
    if (prev_cnt == '1 && o_frame_cnt == '0) saw_wrap = 1;
    prev_cnt = o_frame_cnt;
  endtask

  task automatic step(input bit v, input logic [NB-1:0] d, input bit r, output bit accepted);
    int  tot;
    bit  done_next;
    bit  exp_ready;
    bit  snap;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    #1;
    // A frame completes whenever the padded sample count reaches N_FFT + k*N_HOP.
    tot       = n_acc + PRE;
    done_next = (tot + 1 >= NF) && (((tot + 1 - NF) % NH) == 0);
    exp_ready = !(done_next && exp_valid && !r);
    check("o_ready", W'(o_ready), W'(exp_ready));
    accepted = v && exp_ready;
    snap     = 0;
    if (accepted) begin
      hist.push_back(d);
      if (hist.size() > NF) void'(hist.pop_front());
      n_acc++;
      snap = done_next;
    end
    if (snap) begin
      for (int k = 0; k < NF; k++) exp_frame[k*NB +: NB] = hist[k];
      exp_valid = 1'b1;
      exp_cnt   = exp_cnt + 1'b1;
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    model_reset();
    check_outputs();
    i_rst_n = 1'b1;
  endtask

  initial begin
    bit            acc;
    int            s;
    logic [NB-1:0] first;

    model_reset();
    @(negedge i_clk);
    do_reset();

    // Contiguous ramp: two overlapping frames.
    s = 1;
    while (s <= 48) begin
      step(1, NB'(s), 1, acc);
      if (acc) s++;
    end
    step(0, '0, 1, acc);

    // Backpressure: frame 1 held while samples 33..47 arrive; 48 must wait for i_ready.
    do_reset();
    s = 1;
    while (s <= 31) begin
      step(1, NB'(s), 1, acc);
      if (acc) s++;
    end
    while (s <= 47) begin
      step(1, NB'(s), 0, acc);
      if (acc) s++;
    end
    step(1, NB'(48), 0, acc);
    check("stall_48", W'(acc), W'(0));
    check("held_slice0", W'(o_data[NB-1:0]), W'(1));
    step(1, NB'(48), 1, acc);
    check("accept_48", W'(acc), W'(1));
    step(0, '0, 1, acc);

    // Gapped input: one cycle on, two off.
    s = 49;
    for (int i = 0; i < 64; i++) begin
      step(1, NB'(s), 1, acc);
      if (acc) s++;
      step(0, '0, 1, acc);
      step(0, '0, 1, acc);
    end

    // Random valid/ready/data; long enough to wrap the frame counter.
    for (int i = 0; i < 7000; i++) begin
      step($urandom_range(0, 3) != 0, NB'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    check("cnt_wrap", W'(saw_wrap), W'(1));

    // Reset mid-frame discards the partial frame.
    step(1, NB'($urandom), 1, acc);
    for (int i = 0; i < 20; i++) step(1, NB'($urandom), 1, acc);
    do_reset();
    first = NB'($urandom);
    step(1, first, 1, acc);
    for (int i = 1; i < NF - PRE; i++) step(1, NB'($urandom), 1, acc);
    check("post_rst_valid", W'(o_valid), W'(1));
    check("post_rst_slice", W'(o_data[PRE*NB +: NB]), W'(first));
    for (int i = 0; i < 40; i++) step($urandom_range(0, 1) != 0, NB'($urandom), 1, acc);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
